// File: rtl/move_collector.sv
// Move collector: scans a 16-slot move snapshot into an output FIFO.
// Optional MOVE_CAPTURE_FIRST_EN: two passes, capturing moves first.
module move_collector #(
   parameter int FIFO_DEPTH = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [511:0] moves_in,
   output logic [31:0]  move_out,
   output logic         move_valid,
   input  logic         move_ready,
   output logic         busy,
   output logic         done,
   output logic [4:0]   move_count
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_e;

   state_e        state_q, state_d;
   logic [511:0]  snap_q, snap_d;
   logic [3:0]    idx_q, idx_d;
   logic [4:0]    cnt_q, cnt_d;
   logic [31:0]   mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_q, rd_q;
   logic [AW:0]   occ_q;
   logic [31:0]   slot_w;
   logic          qual, full, push, pop, last;

`ifdef MOVE_CAPTURE_FIRST_EN
   logic          pass_q, pass_d;

   // pass 0 takes captures (piece field set), pass 1 takes quiet moves
   assign qual = (slot_w != 32'h0) &&
                 (pass_q ? (slot_w[29:24] == 6'h0)
                         : (slot_w[29:24] != 6'h0));
   assign last = pass_q && (idx_q == 4'd15);
`else
   assign qual = (slot_w != 32'h0);
   assign last = (idx_q == 4'd15);
`endif

   assign slot_w     = snap_q[{idx_q, 5'b0} +: 32];
   assign full       = (occ_q == DEPTH_C);
   assign move_valid = (occ_q != '0);
   assign pop        = move_valid && move_ready;
   assign move_out   = move_valid ? mem_q[rd_q] : 32'h0;
   assign busy       = (state_q == SCAN) || (state_q == DRAIN);
   assign done       = (state_q == DONE);
   assign move_count = cnt_q;

   always_comb begin
      state_d = state_q;
      snap_d  = snap_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      push    = 1'b0;
`ifdef MOVE_CAPTURE_FIRST_EN
      pass_d  = pass_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = SCAN;
               snap_d  = moves_in;
               idx_d   = 4'd0;
               cnt_d   = 5'd0;
`ifdef MOVE_CAPTURE_FIRST_EN
               pass_d  = 1'b0;
`endif
            end
         end
         SCAN: begin
            if (!(qual && full)) begin
               push  = qual;
               idx_d = idx_q + 4'd1;
               if (qual) cnt_d = cnt_q + 5'd1;
               if (last) state_d = DRAIN;
`ifdef MOVE_CAPTURE_FIRST_EN
               if (idx_q == 4'd15) pass_d = 1'b1;
`endif
            end
         end
         DRAIN: begin
            if (occ_q == '0) state_d = DONE;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         snap_q  <= '0;
         idx_q   <= '0;
         cnt_q   <= '0;
`ifdef MOVE_CAPTURE_FIRST_EN
         pass_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         snap_q  <= snap_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
`ifdef MOVE_CAPTURE_FIRST_EN
         pass_q  <= pass_d;
`endif
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_q  <= '0;
         rd_q  <= '0;
         occ_q <= '0;
      end else begin
         wr_q  <= wr_q + AW'(push);
         rd_q  <= rd_q + AW'(pop);
         occ_q <= occ_q + (AW+1)'(push) - (AW+1)'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_q] <= slot_w;
   end

endmodule

// File: tb/tb_move_collector.sv
// Randomized bench for move_collector against a slot-order queue model.
// Honours MOVE_CAPTURE_FIRST_EN when the design is built with it.
module tb_move_collector;

   localparam int DEPTH = 4;
`ifdef MOVE_CAPTURE_FIRST_EN
   localparam int PASSES = 2;
`else
   localparam int PASSES = 1;
`endif

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic [511:0] moves_in;
   logic [31:0]  move_out;
   logic         move_valid;
   logic         move_ready;
   logic         busy;
   logic         done;
   logic [4:0]   move_count;

   int n_cmp = 0;
   int n_bad = 0;

   move_collector #(.FIFO_DEPTH(DEPTH)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .moves_in   (moves_in),
      .move_out   (move_out),
      .move_valid (move_valid),
      .move_ready (move_ready),
      .busy       (busy),
      .done       (done),
      .move_count (move_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [511:0] rand_snap(input int zero_pct);
      logic [511:0] s;
      logic [31:0]  w;
      s = '0;
      for (int k = 0; k < 16; k++) begin
         w = $urandom;
         if ($urandom_range(0, 1) == 1) w[29:24] = 6'h0;
         if (w == 32'h0) w = 32'h1;
         if ($urandom_range(0, 99) < zero_pct) w = 32'h0;
         s[k*32 +: 32] = w;
      end
      return s;
   endfunction

   // rmode: 0 always ready, 1 random ready, 2 stalled 20 cycles
   task automatic run_txn(input string nm,
                          input logic [511:0] snap,
                          input int rmode,
                          input bit restart);
      logic [31:0] exp_q[$];
      logic [31:0] w;
      int k;
      int done_k;
      int nexp;
      bit seen;
      exp_q = {};
      for (int p = 0; p < PASSES; p++) begin
         for (int s = 0; s < 16; s++) begin
            w = snap[s*32 +: 32];
            if (w != 32'h0) begin
               if (PASSES == 1) exp_q.push_back(w);
               else if ((p == 0) == (w[29:24] != 6'h0))
                  exp_q.push_back(w);
            end
         end
      end
      nexp = exp_q.size();
      @(negedge clk);
      moves_in   = snap;
      start      = 1'b1;
      move_ready = 1'b0;
      k = 0;
      seen = 1'b0;
      done_k = 0;
      while (!seen && k < 3000) begin
         @(negedge clk);
         k++;
         if (k == 1) begin
            start    = 1'b0;
            moves_in = rand_snap(10);
            chk({nm, "_busy_start"}, 32'(busy), 32'd1);
         end
         if (restart && k == 5) begin
            start    = 1'b1;
            moves_in = rand_snap(0);
         end
         if (restart && k == 6) start = 1'b0;
         case (rmode)
            0: move_ready = 1'b1;
            1: move_ready = ($urandom_range(0, 2) != 0);
            default: move_ready = (k > 20);
         endcase
         if (rmode == 2 && k == 20) begin
            chk({nm, "_stall_cnt"}, 32'(move_count), 32'(DEPTH));
            chk({nm, "_stall_vld"}, 32'(move_valid), 32'd1);
         end
         if (move_valid && move_ready) begin
            if (exp_q.size() == 0)
               chk({nm, "_extra_pop"}, move_out, 32'hdead_beef);
            else
               chk({nm, "_word"}, move_out, exp_q.pop_front());
         end
         if (done) begin
            seen   = 1'b1;
            done_k = k;
            chk({nm, "_count"}, 32'(move_count), 32'(nexp));
            chk({nm, "_busy_done"}, 32'(busy), 32'd0);
         end
      end
      chk({nm, "_done_seen"}, 32'(seen), 32'd1);
      chk({nm, "_leftover"}, 32'(exp_q.size()), 32'd0);
      if (nexp == 0)
         chk({nm, "_zero_lat"}, 32'(done_k), 32'(PASSES*16 + 2));
      @(negedge clk);
      chk({nm, "_done_pulse"}, 32'(done), 32'd0);
      chk({nm, "_vld_after"}, 32'(move_valid), 32'd0);
   endtask

   initial begin
      logic [511:0] s;
      reset      = 1'b1;
      start      = 1'b0;
      moves_in   = '0;
      move_ready = 1'b0;
      #12;
      chk("rst_valid", 32'(move_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_count", 32'(move_count), 32'd0);
      chk("rst_out", move_out, 32'd0);
      @(negedge clk);
      reset = 1'b0;

      s = '0;
      s[0*32 +: 32]  = 32'h0001_0203;
      s[3*32 +: 32]  = 32'h0000_1A05;
      s[15*32 +: 32] = 32'h0501_0002;
      run_txn("three", s, 0, 1'b0);

      s = '0;
      s[1*32 +: 32] = 32'h0000_0809;
      s[6*32 +: 32] = 32'h0A00_0910;
      run_txn("capord", s, 0, 1'b0);

      run_txn("allzero", '0, 0, 1'b0);
      run_txn("full", rand_snap(0), 2, 1'b0);
      run_txn("restart", rand_snap(30), 1, 1'b1);

      @(negedge clk);
      moves_in = rand_snap(0);
      start    = 1'b1;
      @(negedge clk);
      start      = 1'b0;
      move_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("pre_rst_vld", 32'(move_valid), 32'd1);
      reset = 1'b1;
      #1;
      chk("mid_rst_vld", 32'(move_valid), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_cnt", 32'(move_count), 32'd0);
      chk("mid_rst_out", move_out, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      run_txn("after_rst", rand_snap(25), 1, 1'b0);

      for (int i = 0; i < 20; i++)
         run_txn("rand", rand_snap($urandom_range(0, 90)),
                 $urandom_range(0, 1), i[0]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/move_collector.md
MOVE_COLLECTOR -- requirements
Module: move_collector

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, output FIFO entries (power of 2, 2..16).
REQ-002 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  one-cycle request to collect the current square's moves.
REQ-005 SHALL have port moves_in  input  512  16 packed 32-bit move words; slot k = bits [32k+31:32k]; order U,D,L,R,UL,UR,DL,DR,UUL,UUR,LLU,RRU,DDL,DDR,LLD,RRD (k=0..15).
REQ-006 SHALL have port move_out  output  32  head-of-FIFO move word.
REQ-007 SHALL have port move_valid  output  1  move_out holds a valid move.
REQ-008 SHALL have port move_ready  input  1  consumer accepts move_out when high with move_valid.
REQ-009 SHALL have port busy  output  1  high from the cycle after an accepted start until done.
REQ-010 SHALL have port done  output  1  one-cycle pulse when collection and drain are complete.
REQ-011 SHALL have port move_count  output  5  moves pushed since the last accepted start (0..16).

Function
REQ-012 SHALL implement states IDLE, SCAN, DRAIN, DONE.
REQ-013 In IDLE, start SHALL snapshot moves_in into an internal 512-bit register, clear move_count and slot index, and enter SCAN next cycle.
REQ-014 start while not in IDLE SHALL be ignored; snapshot and count unchanged.
REQ-015 In SCAN, one slot SHALL be examined per cycle, in ascending index order.
REQ-016 A slot word equal to 32'h0000_0000 is empty and SHALL be skipped without a push; the index advances.
REQ-017 A nonzero slot word SHALL be pushed unmodified when the FIFO is not full (registered occupancy < FIFO_DEPTH); index advances, move_count increments.
REQ-018 A nonzero slot with FIFO full SHALL stall the index; no push, no drop; the slot is retried each cycle.
REQ-019 After the last slot is processed, the FSM SHALL enter DRAIN; DRAIN waits for FIFO occupancy 0, then enters DONE.
REQ-020 DONE SHALL last one cycle with done=1, then return to IDLE; busy=0 in DONE and IDLE.
REQ-021 FIFO SHALL be first-in first-out; a pushed word appears on move_out no earlier than the next cycle.
REQ-022 Pop SHALL occur only when move_valid && move_ready; simultaneous push and pop in one cycle SHALL both take effect, occupancy unchanged.
REQ-023 move_valid SHALL be high exactly when occupancy > 0; move_out is don't-care when move_valid=0.
REQ-024 moves_in changes after the start cycle SHALL NOT affect the collection in progress.
REQ-025 A snapshot with all 16 slots zero SHALL pass SCAN in 16 cycles, DRAIN in 1 cycle, and pulse done with move_count=0.

Reset
REQ-026 Asserting reset at any time, including mid-SCAN or mid-DRAIN, SHALL immediately force IDLE, FIFO empty, index 0, and all outputs to 0 (move_out=0, move_valid=0, busy=0, done=0, move_count=0).
REQ-027 The first start SHALL be accepted on the first rising edge after reset deasserts.

Configuration
REQ-028 With macro MOVE_CAPTURE_FIRST_EN defined, SCAN SHALL make two passes over slots 0..15: pass 0 pushes only nonzero words with captured-piece field bits [29:24] != 0; pass 1 pushes only nonzero words with bits [29:24] == 0; minimum SCAN length 32 cycles.
REQ-029 Without MOVE_CAPTURE_FIRST_EN, SCAN SHALL be a single pass pushing every nonzero word in slot order; minimum SCAN length 16 cycles.

Verification
REQ-030 Slots 0,3,15 = 32'h0001_0203, 32'h0000_1A05, 32'h0501_0002, rest 0, move_ready=1 -> move_out sequence 0001_0203, 0000_1A05, 0501_0002; move_count=3; one done pulse.
REQ-031 All 16 slots nonzero, FIFO_DEPTH=4, move_ready=0 for 20 cycles then 1 -> index stalls at slot 4, no loss; all 16 words emitted in order; move_count=16.
REQ-032 start pulsed again mid-SCAN with different moves_in -> ignored; output matches first snapshot only.
REQ-033 reset asserted while 2 entries queued in SCAN -> same cycle move_valid=0, busy=0, move_count=0; next start collects fresh snapshot correctly.
REQ-034 With MOVE_CAPTURE_FIRST_EN: slot 1 = 32'h0000_0809 (quiet), slot 6 = 32'h0A00_0910 (capture) -> order 0A00_0910 then 0000_0809; without macro -> reverse order.
REQ-035 All slots zero -> done pulse 18 cycles after start (16 SCAN + DRAIN + DONE), move_valid never high.
